// File: rtl/matrix_row_serializer.sv
// matrix_row_serializer
// Buffers ROWSxCOLS result words in a small FIFO and replays each word one
// row at a time over a valid/accept handshake. Row 0 is the top COLS bits.
// Words that arrive while the FIFO is full are dropped and flagged.
module matrix_row_serializer #(
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROWS*COLS-1:0]   in,
    input  logic                   inValid,
    output logic                   canAccept,
    output logic [COLS-1:0]        rowOut,
    output logic                   rowValid,
    input  logic                   rowAccept,
    output logic                   lastRow,
    output logic                   overflow,
    output logic                   empty
);

    localparam int W  = ROWS * COLS;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [W-1:0]    shift_reg;
    logic [RW-1:0]   row_cnt_reg;
    logic            overflow_reg;

    logic            load;
    logic            shift;
    logic            push;
    logic            fifo_full;
    logic            fifo_has_word;

    assign fifo_full     = (count_reg == FULL_COUNT);
    assign fifo_has_word = (count_reg != '0);

    // A pop in the same cycle frees a slot, so a full FIFO can still take a word.
    assign push = inValid && (!fifo_full || load);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: decides when to load (pop) a word and when to shift a row out.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        shift      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fifo_has_word) begin
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (rowAccept) begin
                    if (row_cnt_reg == LAST_ROW) begin
                        // Chain straight into the next word to avoid a bubble.
                        if (fifo_has_word) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO storage write port; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (load) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, load})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (inValid && !push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Shift register doubles as the registered RAM read; row counter tracks position in the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg   <= '0;
            row_cnt_reg <= '0;
        end else if (load) begin
            shift_reg   <= mem[rd_ptr_reg];
            row_cnt_reg <= '0;
        end else if (shift) begin
            shift_reg   <= shift_reg << COLS;
            row_cnt_reg <= row_cnt_reg + RW'(1);
        end
    end

    assign rowOut    = shift_reg[W-1 -: COLS];
    assign rowValid  = (state_reg == SEND);
    assign lastRow   = (state_reg == SEND) && (row_cnt_reg == LAST_ROW);
    assign canAccept = !fifo_full;
    assign overflow  = overflow_reg;
    assign empty     = !fifo_has_word && (state_reg == IDLE);

endmodule

// File: tb/tb_matrix_row_serializer.sv
// Self-checking bench for matrix_row_serializer. Every pushed word queues its
// expected rows; a negedge monitor compares each presented row against the
// head of that queue and retires it when the consumer accepts.
module tb_matrix_row_serializer;

    localparam int ROWS  = 5;
    localparam int COLS  = 5;
    localparam int DEPTH = 2;
    localparam int W     = ROWS * COLS;

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    in_word;
    logic            inValid;
    logic            canAccept;
    logic [COLS-1:0] rowOut;
    logic            rowValid;
    logic            rowAccept;
    logic            lastRow;
    logic            overflow;
    logic            empty;

    logic [COLS:0]   exp_q [$];   // {last_flag, row}
    int              n_checks = 0;
    int              n_fail   = 0;

    localparam logic [W-1:0] WORD_T1 = 25'b11111_00000_10101_01010_00001;

    always #5 clk = ~clk;

    matrix_row_serializer #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_word),
        .inValid   (inValid),
        .canAccept (canAccept),
        .rowOut    (rowOut),
        .rowValid  (rowValid),
        .rowAccept (rowAccept),
        .lastRow   (lastRow),
        .overflow  (overflow),
        .empty     (empty)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Row monitor: every presented row must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (rowValid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_row_valid", {31'b0, rowValid}, 32'd0);
                end else begin
                    check_eq("row_data", {27'b0, rowOut}, {27'b0, exp_q[0][COLS-1:0]});
                    check_eq("row_last", {31'b0, lastRow}, {31'b0, exp_q[0][COLS]});
                    $display("row %b last=%0b accept=%0b", rowOut, lastRow, rowAccept);
                    if (rowAccept) begin
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check_eq("last_without_valid", {31'b0, lastRow}, 32'd0);
            end
        end
    end

    task automatic push_word(input logic [W-1:0] w, input bit track);
        logic last_b;
        in_word = w;
        inValid = 1'b1;
        if (track) begin
            for (int r = 0; r < ROWS; r++) begin
                last_b = (r == ROWS - 1);
                exp_q.push_back({last_b, w[W-1-r*COLS -: COLS]});
            end
        end
        $display("push %h tracked=%0b", w, track);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        inValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check_eq("rst_rowValid",  {31'b0, rowValid},  32'd0);
        check_eq("rst_lastRow",   {31'b0, lastRow},   32'd0);
        check_eq("rst_overflow",  {31'b0, overflow},  32'd0);
        check_eq("rst_rowOut",    {27'b0, rowOut},    32'd0);
        check_eq("rst_canAccept", {31'b0, canAccept}, 32'd1);
        check_eq("rst_empty",     {31'b0, empty},     32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (empty && exp_q.size() == 0) break;
        end
        check_eq({tag, "_empty"}, {31'b0, empty}, 32'd1);
        check_eq({tag, "_scoreboard_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        inValid   = 1'b0;
        rowAccept = 1'b0;
        in_word   = '0;
        do_reset();

        // Single word at full rate with first-row latency.
        rowAccept = 1'b1;
        push_word(WORD_T1, 1'b1);
        @(negedge clk);
        check_eq("lat_cycle1_valid", {31'b0, rowValid}, 32'd0);
        @(negedge clk);
        check_eq("lat_cycle2_valid", {31'b0, rowValid}, 32'd1);
        check_eq("lat_first_row", {27'b0, rowOut}, 32'h1f);
        wait_idle("single");

        // Backpressure: consumer accepts every other cycle.
        rowAccept = 1'b0;
        push_word(WORD_T1, 1'b1);
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            rowAccept = ~rowAccept;
        end
        rowAccept = 1'b1;
        wait_idle("backpressure");

        // Back-to-back words must stream without a gap.
        rowAccept = 1'b1;
        push_word({W{1'b1}}, 1'b1);
        push_word({W{1'b0}}, 1'b1);
        for (int i = 0; i < 2 * ROWS; i++) begin
            @(negedge clk);
            check_eq("b2b_no_bubble", {31'b0, rowValid}, 32'd1);
        end
        @(negedge clk);
        check_eq("b2b_done_valid", {31'b0, rowValid}, 32'd0);
        check_eq("b2b_done_empty", {31'b0, empty}, 32'd1);

        // Overflow: three words fill SEND plus the FIFO, the fourth is dropped.
        rowAccept = 1'b0;
        push_word(W'($urandom), 1'b1);
        push_word(W'($urandom), 1'b1);
        push_word(W'($urandom), 1'b1);
        @(negedge clk);
        check_eq("ovf_full_canAccept", {31'b0, canAccept}, 32'd0);
        check_eq("ovf_before_drop", {31'b0, overflow}, 32'd0);
        push_word(W'($urandom), 1'b0);
        @(negedge clk);
        check_eq("ovf_set", {31'b0, overflow}, 32'd1);
        rowAccept = 1'b1;
        wait_idle("overflow_drain");
        check_eq("ovf_sticky", {31'b0, overflow}, 32'd1);

        // Reset in the middle of a word, then a fresh word starts at row 0.
        rowAccept = 1'b1;
        push_word(WORD_T1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rowAccept = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check_eq("midrst_rowValid", {31'b0, rowValid}, 32'd0);
        check_eq("midrst_empty",    {31'b0, empty},    32'd1);
        check_eq("midrst_overflow", {31'b0, overflow}, 32'd0);
        rowAccept = 1'b1;
        push_word(WORD_T1, 1'b1);
        @(negedge clk);
        check_eq("midrst_lat1", {31'b0, rowValid}, 32'd0);
        @(negedge clk);
        check_eq("midrst_row0", {27'b0, rowOut}, 32'h1f);
        wait_idle("midrst");

        // Full FIFO with a push landing on the last-row accept (simultaneous pop).
        rowAccept = 1'b0;
        push_word(W'($urandom), 1'b1);
        push_word(W'($urandom), 1'b1);
        push_word(W'($urandom), 1'b1);
        check_eq("simul_full", {31'b0, canAccept}, 32'd0);
        rowAccept = 1'b1;
        repeat (ROWS - 1) @(posedge clk);
        #1;
        check_eq("simul_at_last_row", {31'b0, lastRow}, 32'd1);
        push_word(W'($urandom), 1'b1);
        check_eq("simul_no_overflow", {31'b0, overflow}, 32'd0);
        check_eq("simul_still_full", {31'b0, canAccept}, 32'd0);
        wait_idle("simul");
        check_eq("simul_overflow_end", {31'b0, overflow}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_row_serializer.md
Name: matrix_row_serializer

Overview:
- Downstream stage of the matrix re-evaluation unit.
- Captures each 25-bit (5x5) result word when the producer flags it ready, and buffers it in a small FIFO.
- Emits the word one 5-bit row at a time over a valid/accept handshake to the output/display side.
- Decouples the evaluator from a slow consumer and flags words lost to backpressure.

Parameters:
- ROWS, 5, rows per matrix word.
- COLS, 5, bits per row; word width W = ROWS*COLS.
- DEPTH, 2, FIFO depth in words (power of 2, >=2).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  W  matrix word from evaluator; row 0 = bits [W-1 : W-COLS].
- inValid  in  1  one-cycle pulse, driven by evaluator outReady; captures in.
- canAccept  out  1  high when FIFO not full.
- rowOut  out  COLS  current row, MSB = column 0.
- rowValid  out  1  rowOut holds a valid row.
- rowAccept  in  1  consumer takes rowOut this cycle.
- lastRow  out  1  rowValid and current row is row ROWS-1.
- overflow  out  1  sticky; a word arrived while full and was dropped.
- empty  out  1  FIFO count == 0 and serializer idle.

Behaviour:
- Reset (synchronous, active-high, any cycle including mid-word):
  - FIFO pointers and count = 0; state = IDLE; row counter = 0; shift register = 0.
  - Outputs: rowValid = 0, lastRow = 0, overflow = 0, rowOut = 0, canAccept = 1, empty = 1.
  - Any partially sent word is discarded.
- FIFO push: on inValid when count < DEPTH, write in at wrPtr; wrPtr wraps modulo DEPTH.
- FIFO full:
  - inValid with count == DEPTH and no pop in the same cycle: word dropped, overflow set; overflow stays set until rst.
  - Same-cycle pop frees a slot: push accepted, count unchanged.
- canAccept = (count < DEPTH), from registered count.
- State machine:
  - IDLE: if count != 0, load head word into shift register, pop (rdPtr+1, count-1), row counter = 0, go to SEND.
  - SEND: rowValid = 1; rowOut = shift register top COLS bits.
    - On rowAccept with row counter < ROWS-1: shift register left by COLS, counter+1.
    - On rowAccept with counter == ROWS-1: if count != 0, load and pop next word, counter = 0, stay in SEND (no bubble); else go to IDLE.
    - Without rowAccept: rowOut, rowValid and counter hold.
- Latency: word pushed at edge E reaches IDLE next cycle, giving first rowValid high in cycle E+2. One row per accepted cycle at full rate.
- count update: +1 for push, -1 for pop, unchanged when both occur.
- lastRow = (state == SEND) && (counter == ROWS-1).
- empty = (count == 0) && (state == IDLE).
- rowAccept while rowValid = 0 is ignored.

Test Plan:
- Single word: in = 11111_00000_10101_01010_00001 pulsed once, rowAccept held 1 -> rows 11111, 00000, 10101, 01010, 00001 on 5 consecutive cycles. First row 2 cycles after push; lastRow only on 00001; then empty = 1.
- Backpressure: same word, rowAccept toggling 1/0 -> each row held stable while rowAccept = 0; no row skipped or repeated.
- Back-to-back: two words A = all ones, B = all zeros pushed on consecutive cycles -> 10 rows with no idle cycle between A's last row and B's first row.
- Overflow: rowAccept = 0 with 3 words pushed (DEPTH = 2) -> first word loaded into SEND, 2 buffered, canAccept = 0. A 4th push sets overflow = 1 and that word never appears. overflow stays 1 after draining.
- Full with simultaneous pop: FIFO full, inValid on the same cycle a last-row accept pops -> word accepted, overflow stays 0, count stays DEPTH.
- Reset mid-word: rst asserted after 2 rows of a word -> next cycle rowValid = 0, empty = 1, overflow = 0. A new word then starts from its row 0.
